// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared channel indices, default debounce length and FIFO sizing helper
package game_pkg;

  localparam int CH_RIGHT   = 0;
  localparam int CH_DOWN    = 1;
  localparam int CH_LEFT    = 2;
  localparam int CH_UP      = 3;
  localparam int CH_RESTART = 4;

  // 10 ms at 100 MHz
  localparam int DEB_CYCLES_DEFAULT = 1000000;

  // Occupancy counter must represent 0..depth inclusive
  function automatic int fifo_occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/game_input_ctrl_if.sv
// rtl/game_input_ctrl_if.sv - command valid/ready handshake between input controller and game kernel
interface game_input_ctrl_if #(
  parameter int N_BTN = 5
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [N_BTN-1:0] cmd_code;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-channel 2-FF synchroniser, debounce counter and press-edge pulse
module btn_debounce import game_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int                CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], raw};
  end

  // Accept a level change only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered one-cycle pulse on the rising edge of the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// rtl/game_input_ctrl.sv - debounced button arbitration and command FIFO; GAME_INPUT_AUTO_REPEAT_EN adds held-move auto-repeat
module game_input_ctrl import game_pkg::*; #(
  parameter int N_BTN         = 5,
  parameter int DEB_CYCLES    = DEB_CYCLES_DEFAULT,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 15000000
) (
  input  logic                                 CLK_100M,
  input  logic                                 RST_N,
  input  logic [N_BTN-1:0]                     btn_raw,
  input  logic                                 clr_ovf,
  game_input_ctrl_if.master                    cmd,
  output logic [N_BTN-1:0]                     btn_level,
  output logic [fifo_occ_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                                 ovf_flag,
  output logic                                 coll_flag
);

  localparam int OCC_W = fifo_occ_width(FIFO_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (N_BTN < 2) begin : g_bad_nbtn
    $error("game_input_ctrl: N_BTN must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("game_input_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("game_input_ctrl: repeat intervals must be positive");
  end

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] press_all;
  logic [N_BTN-2:0] rep_move;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (CLK_100M),
      .rst_n (RST_N),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (press[i])
    );
  end

`ifdef GAME_INPUT_AUTO_REPEAT_EN
  logic [31:0]      rep_cnt [N_BTN-1];
  logic [N_BTN-2:0] rep_first;

  // Per-move repeat timers: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      rep_move  <= '0;
      rep_first <= '1;
      for (int i = 0; i < N_BTN-1; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN-1; i++) begin
        rep_move[i] <= 1'b0;
        if (!btn_level[i] || press[N_BTN-1] || press[i]) begin
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b1;
        end else if (rep_cnt[i] == (rep_first[i] ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1))) begin
          rep_move[i]  <= 1'b1;
          rep_cnt[i]   <= '0;
          rep_first[i] <= 1'b0;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 32'd1;
        end
      end
    end
  end
`else
  assign rep_move = '0;
`endif

  assign press_all = press | {1'b0, rep_move};

  logic [N_BTN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] count_q;

  logic             restart, full, pop, do_push, ovf_set, coll_set;
  logic [N_BTN-2:0] moves, win;
  logic [N_BTN-1:0] push_code;

  // Arbitration: restart dominates, otherwise lowest-index move wins
  always_comb begin
    restart   = press_all[N_BTN-1];
    moves     = press_all[N_BTN-2:0];
    win       = moves & (~moves + 1'b1);
    full      = (count_q == OCC_W'(FIFO_DEPTH));
    pop       = cmd.cmd_valid & cmd.cmd_ready;
    do_push   = !restart && (|moves) && (!full || pop);
    ovf_set   = !restart && (|moves) && full && !pop;
    coll_set  = !restart && (|(moves & (moves - 1'b1)));
    push_code = restart ? {1'b1, {(N_BTN-1){1'b0}}} : {1'b0, win};
  end

  // FIFO pointers and occupancy; a restart collapses the queue to a single entry
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (restart) begin
      rd_ptr  <= '0;
      wr_ptr  <= PTR_W'(1);
      count_q <= OCC_W'(1);
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are masked by cmd_valid so no reset is needed
  always_ff @(posedge CLK_100M) begin
    if (restart)      mem[0]      <= push_code;
    else if (do_push) mem[wr_ptr] <= push_code;
  end

  // Sticky flags; a set event in the same cycle beats the clear
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      ovf_flag  <= 1'b0;
      coll_flag <= 1'b0;
    end else begin
      ovf_flag  <= ovf_set  | (ovf_flag  & ~clr_ovf);
      coll_flag <= coll_set | (coll_flag & ~clr_ovf);
    end
  end

  assign fifo_count    = count_q;
  assign cmd.cmd_valid = (count_q != '0);
  assign cmd.cmd_code  = cmd.cmd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_game_input_ctrl.sv
// tb/tb_game_input_ctrl.sv - self-checking bench for game_input_ctrl with a behavioural queue model
module tb_game_input_ctrl;
  import game_pkg::*;

  localparam int N     = 5;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = '0;
  logic       clr_ovf = 1'b0;
  logic [4:0] btn_level;
  logic [2:0] fifo_count;
  logic       ovf_flag, coll_flag;

  int n_tests = 0;
  int n_fail  = 0;

  game_input_ctrl_if #(.N_BTN(N)) cmd_bus ();

  game_input_ctrl #(
    .N_BTN(N), .DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH),
    .REPEAT_DELAY(40), .REPEAT_PERIOD(20)
  ) dut (
    .CLK_100M   (clk),
    .RST_N      (rst_n),
    .btn_raw    (btn_raw),
    .clr_ovf    (clr_ovf),
    .cmd        (cmd_bus),
    .btn_level  (btn_level),
    .fifo_count (fifo_count),
    .ovf_flag   (ovf_flag),
    .coll_flag  (coll_flag)
  );

  always #5 clk = ~clk;

  // Reference model: sampled-input history, a window of the last DEB synchronised
  // samples per channel, and a plain queue of commands.
  bit [4:0] m_s1, m_s2, m_lvl, m_lvl_d, m_press, m_nl;
  bit [4:0] m_win [DEB];
  bit [4:0] m_q [$];
  bit       m_ovf, m_coll, m_pop, m_all_diff;
  bit [4:0] m_one;
  bit [3:0] m_mv;
  int       m_old_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_press = '0;
      for (int j = 0; j < DEB; j++) m_win[j] = '0;
      m_q.delete();
      m_ovf = 1'b0; m_coll = 1'b0;
    end else begin
      m_old_n = m_q.size();
      m_pop   = (m_old_n > 0) && cmd_bus.cmd_ready;
      if (clr_ovf) begin m_ovf = 1'b0; m_coll = 1'b0; end
      if (m_press[CH_RESTART]) begin
        m_q.delete();
        m_q.push_back(5'b10000);
      end else begin
        m_mv = m_press[3:0];
        if (m_pop) void'(m_q.pop_front());
        if (m_mv != 0) begin
          for (int c = 0; c < 4; c++) begin
            if (m_mv[c]) begin
              m_one = 5'b00001;
              if (m_old_n < DEPTH || m_pop) m_q.push_back(m_one << c);
              else m_ovf = 1'b1;
              break;
            end
          end
          if ($countones(m_mv) > 1) m_coll = 1'b1;
        end
      end
      m_press = m_lvl & ~m_lvl_d;
      m_lvl_d = m_lvl;
      for (int j = DEB-1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      m_nl = m_lvl;
      for (int c = 0; c < N; c++) begin
        m_all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (m_win[j][c] == m_lvl[c]) m_all_diff = 1'b0;
        if (m_all_diff) m_nl[c] = ~m_lvl[c];
      end
      m_lvl = m_nl;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic press_btn(input int c);
    btn_raw[c] = 1'b1;
    repeat (8) @(negedge clk);
    btn_raw[c] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain();
    cmd_bus.cmd_ready = 1'b1;
    for (int i = 0; i < 20 && cmd_bus.cmd_valid; i++) @(negedge clk);
    n_tests++;
    if (cmd_bus.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: cmd_valid=%b expected 0", cmd_bus.cmd_valid);
    end
    cmd_bus.cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_raw = 5'b00001;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cmd_bus.cmd_valid, cmd_bus.cmd_code, btn_level, fifo_count, ovf_flag, coll_flag} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b code=%b level=%b count=%0d ovf=%b coll=%b expected all 0",
               cmd_bus.cmd_valid, cmd_bus.cmd_code, btn_level, fifo_count, ovf_flag, coll_flag);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_tests++;
      if (cmd_bus.cmd_valid !== (k == 8)) begin
        n_fail++;
        $display("FAIL reset_latency cycle %0d: cmd_valid=%b expected %b", k, cmd_bus.cmd_valid, (k == 8));
      end
    end
    n_tests++;
    if (cmd_bus.cmd_code !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_code: cmd_code=%b expected 00001", cmd_bus.cmd_code);
    end
    btn_raw = '0;
    repeat (8) @(negedge clk);
    drain();
  endtask

  task automatic test_glitch();
    btn_raw[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_tests++;
      if ({btn_level, cmd_bus.cmd_valid, fifo_count, ovf_flag, coll_flag} !== '0) begin
        n_fail++;
        $display("FAIL glitch cycle %0d: level=%b valid=%b count=%0d ovf=%b coll=%b expected all 0",
                 k, btn_level, cmd_bus.cmd_valid, fifo_count, ovf_flag, coll_flag);
      end
    end
  endtask

  task automatic test_collision();
    cmd_bus.cmd_ready = 1'b0;
    btn_raw = 5'b00101;
    repeat (12) @(negedge clk);
    n_tests++;
    if ({fifo_count, cmd_bus.cmd_code, coll_flag, ovf_flag} !== {3'd1, 5'b00001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL collision: count=%0d code=%b coll=%b ovf=%b expected 1 00001 1 0",
               fifo_count, cmd_bus.cmd_code, coll_flag, ovf_flag);
    end
    btn_raw = '0;
    repeat (8) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_tests++;
    if (coll_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_clear: coll_flag=%b expected 0", coll_flag);
    end
    drain();
  endtask

  task automatic test_overflow();
    cmd_bus.cmd_ready = 1'b0;
    for (int p = 0; p < 5; p++) press_btn(CH_DOWN);
    n_tests++;
    if ({fifo_count, ovf_flag, cmd_bus.cmd_valid} !== {3'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow: count=%0d ovf=%b valid=%b expected 4 1 1", fifo_count, ovf_flag, cmd_bus.cmd_valid);
    end
    cmd_bus.cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({cmd_bus.cmd_valid, cmd_bus.cmd_code} !== {1'b1, 5'b00010}) begin
        n_fail++;
        $display("FAIL overflow_pop %0d: valid=%b code=%b expected 1 00010", k, cmd_bus.cmd_valid, cmd_bus.cmd_code);
      end
      @(negedge clk);
    end
    cmd_bus.cmd_ready = 1'b0;
    n_tests++;
    if ({cmd_bus.cmd_valid, fifo_count} !== 4'b0000) begin
      n_fail++;
      $display("FAIL overflow_empty: valid=%b count=%0d expected 0 0", cmd_bus.cmd_valid, fifo_count);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
  endtask

  task automatic test_restart();
    logic [2:0] prev;
    bit found;
    cmd_bus.cmd_ready = 1'b0;
    press_btn(CH_RIGHT);
    press_btn(CH_DOWN);
    press_btn(CH_LEFT);
    n_tests++;
    if (fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL restart_fill: count=%0d expected 3", fifo_count);
    end
    btn_raw[CH_RESTART] = 1'b1;
    prev  = fifo_count;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_bus.cmd_code === 5'b10000) begin found = 1'b1; break; end
      prev = fifo_count;
    end
    n_tests++;
    if (!found || prev !== 3'd3 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL restart_flush: seen=%b count_before=%0d count=%0d code=%b expected 1 3 1 10000",
               found, prev, fifo_count, cmd_bus.cmd_code);
    end
    btn_raw[CH_RESTART] = 1'b0;
    repeat (8) @(negedge clk);
    drain();
  endtask

  task automatic test_random();
    int hold [N];
    bit [4:0] exp_code;
    bit [2:0] exp_cnt;
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_cnt  = 3'(m_q.size());
      exp_code = (m_q.size() != 0) ? m_q[0] : 5'b0;
      n_tests++;
      if ({cmd_bus.cmd_valid, cmd_bus.cmd_code, fifo_count, btn_level, ovf_flag, coll_flag} !==
          {(exp_cnt != 0), exp_code, exp_cnt, m_lvl, m_ovf, m_coll}) begin
        n_fail++;
        $display("FAIL random cycle %0d: valid=%b code=%b count=%0d level=%b ovf=%b coll=%b expected %b %b %0d %b %b %b",
                 cyc, cmd_bus.cmd_valid, cmd_bus.cmd_code, fifo_count, btn_level, ovf_flag, coll_flag,
                 (exp_cnt != 0), exp_code, exp_cnt, m_lvl, m_ovf, m_coll);
      end
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          if (c == CH_RESTART) btn_raw[c] = ($urandom_range(0, 5) == 0);
          else                 btn_raw[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end else begin
          hold[c]--;
        end
      end
      cmd_bus.cmd_ready = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 19) == 0);
    end
    btn_raw = '0;
    clr_ovf = 1'b0;
    cmd_bus.cmd_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    repeat (10) @(negedge clk);
    drain();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    press_btn(CH_RIGHT);
    press_btn(CH_UP);
    press_btn(CH_LEFT);
    cmd_bus.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_bus.cmd_ready = 1'b0;
    n_tests++;
    if (fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_reset_setup: count=%0d expected 2", fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cmd_bus.cmd_valid, fifo_count} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_async: valid=%b count=%0d expected 0 0", cmd_bus.cmd_valid, fifo_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cmd_bus.cmd_ready = 1'b0;
    test_reset();
    test_glitch();
    test_collision();
    test_overflow();
    test_restart();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_input_ctrl.md
Name: game_input_ctrl

Overview:
- Parametrised successor to the ad-hoc button wiring in the game top level.
- Takes N raw button/switch lines, then synchronises, debounces and edge-detects each one.
- Arbitrates same-cycle presses, buffers one-hot commands in a small FIFO, and presents them to the game kernel over a valid/ready handshake.
- Sits between the board I/O pins and game_control; replaces the direct user_operation bus.

Parameters:
- N_BTN, 5, number of input channels; channel N_BTN-1 is the restart channel; channels 0..N_BTN-2 are moves.
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- REPEAT_DELAY, 50000000, cycles before the first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 15000000, cycles between later auto-repeats (used only with AUTO_REPEAT_EN).

Ports:
- CLK_100M  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw asynchronous buttons, active high.
- cmd_ready  in  1  kernel accepts the head command.
- clr_ovf  in  1  synchronous clear of the sticky flags.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  N_BTN  one-hot head command.
- btn_level  out  N_BTN  debounced levels.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- ovf_flag  out  1  sticky: a command was dropped because the FIFO was full.
- coll_flag  out  1  sticky: a move was dropped by arbitration.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Sync flops, debounced levels, counters, FIFO pointers and flags all clear.
  - cmd_valid=0, cmd_code=0, btn_level=0, fifo_count=0, ovf_flag=0, coll_flag=0.
  - Reset mid-operation discards all queued commands.
- Synchronisation: 2-FF synchroniser per channel.
- Debounce, per channel:
  - The counter resets whenever the synchronised input equals btn_level.
  - Otherwise it increments; at DEB_CYCLES-1 btn_level toggles and the counter clears.
  - Glitches shorter than DEB_CYCLES never toggle btn_level.
- Edge detection: press pulse = rising edge of btn_level (1 cycle). Releases generate nothing.
- Arbitration, per cycle:
  - Restart press: the FIFO is flushed and the restart command (one-hot bit N_BTN-1) is written as its only entry, in the same cycle. Other presses in that cycle are dropped without setting coll_flag.
  - Otherwise, with several move presses, the lowest index wins; the others are dropped and coll_flag is set.
- FIFO:
  - Registered output; cmd_code = head entry; cmd_valid = (count != 0).
  - Pop when cmd_valid && cmd_ready.
  - Push when a press wins arbitration.
  - Push while full: if a pop happens in the same cycle, both proceed and count is unchanged; otherwise the push is dropped and ovf_flag is set.
  - Pop and push in the same cycle while empty: only the push is effective; cmd_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags: clr_ovf clears both flags. A set event in the same cycle wins over the clear.
- Latency: with an empty FIFO and a clean press, cmd_valid rises exactly DEB_CYCLES+4 cycles after the first posedge at which btn_raw is sampled high (2 synchroniser cycles + DEB_CYCLES debounce + 1 edge + 1 write).
- cmd_code holds stable while cmd_valid=1 and cmd_ready=0.

Optional Feature:
- Macro: GAME_INPUT_AUTO_REPEAT_EN.
- Defined:
  - A move channel held at btn_level=1 generates a repeat press REPEAT_DELAY cycles after its initial press, then every REPEAT_PERIOD cycles.
  - Repeat presses pass through the same arbitration and FIFO rules.
  - Release, or a restart press, cancels all repeat timers.
  - The restart channel never repeats.
- Undefined: no repeat counters are synthesised; exactly one command per press.

Decomposition:
- Shared package game_pkg holds:
  - localparams for the channel indices: CH_RIGHT=0, CH_DOWN=1, CH_LEFT=2, CH_UP=3, CH_RESTART=4.
  - the default DEB_CYCLES.
  - the FIFO occupancy width function.
- One sub-module, btn_debounce: single-channel synchroniser + counter + edge detect. Instantiated N_BTN times via generate.
- FIFO and arbitration stay in the parent.

Test Plan (DEB_CYCLES=4, FIFO_DEPTH=4, N_BTN=5):
- Reset with btn_raw=5'b00001 held -> all outputs 0 during reset; after RST_N rises, cmd_valid=1 at exactly cycle 8, cmd_code=5'b00001.
- btn_raw[1] pulsed high for 3 cycles -> btn_level stays 0, no command, flags remain 0.
- btn_raw[0] and btn_raw[2] rise together, cmd_ready=0 -> one entry cmd_code=5'b00001, coll_flag=1; clr_ovf pulse -> coll_flag=0.
- Five separate presses of bit 1 with cmd_ready=0 -> fifo_count=4, ovf_flag=1; cmd_ready=1 for 4 cycles -> four pops of 5'b00010, then cmd_valid=0.
- FIFO holding 3 moves, then a bit-4 press -> next cycle fifo_count=1, cmd_code=5'b10000.
- RST_N low mid-drain with fifo_count=2 -> asynchronously cmd_valid=0, fifo_count=0.
